// File: rtl/mask_pkg.sv
// Shared types and defaults for the mask (amplitude-shift) modulator.
// sine_q builds the carrier table at elaboration time.
package mask_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam int          DEF_DATA_W       = 16;
    localparam int          DEF_BITS_PER_SYM = 2;
    localparam int          DEF_SYM_LEN      = 256;
    localparam int          DEF_PHASE_W      = 16;
    localparam int          DEF_LUT_AW       = 8;
    localparam int          DEF_FIFO_DEPTH   = 4;
    localparam logic [15:0] DEF_IDLE_OUT     = 16'h2710;

    localparam real PI = 3.14159265358979323846;

    // round(sin(2*pi*idx/2**aw) * (2**(dw-1)-1)); a Taylor series on (-pi, pi]
    // keeps this free of math-library calls during constant evaluation.
    function automatic int sine_q(input int idx, input int aw, input int dw);
        real x, term, acc, amp, n_ent;
        n_ent = 1.0;
        for (int b = 0; b < aw; b++) n_ent = n_ent * 2.0;
        amp = 1.0;
        for (int b = 0; b < dw - 1; b++) amp = amp * 2.0;
        amp = amp - 1.0;
        x = 2.0 * PI * real'(idx) / n_ent;
        if (x > PI) x = x - 2.0 * PI;
        term = x;
        acc  = x;
        for (int n = 1; n < 24; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        acc = acc * amp;
        return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
    endfunction

endpackage

// File: rtl/mask_sine_lut.sv
// Combinational full-period sine table, one signed DATA_W entry per address.
module mask_sine_lut
    import mask_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LUT_AW = DEF_LUT_AW
) (
    input  logic        [LUT_AW-1:0] addr,
    output logic signed [DATA_W-1:0] sample
);

    logic signed [DATA_W-1:0] tab [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_tab
        localparam int V = sine_q(i, LUT_AW, DATA_W);
        assign tab[i] = DATA_W'(V);
    end

    assign sample = tab[addr];

endmodule

// File: rtl/mask_modulator.sv
// Symbol FIFO feeding an amplitude-keyed NCO: each symbol level k scales the
// carrier by k/M for SYM_LEN cycles; the output holds IDLE_OUT when not sending.
module mask_modulator
    import mask_pkg::*;
#(
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                BITS_PER_SYM = DEF_BITS_PER_SYM,
    parameter int                SYM_LEN      = DEF_SYM_LEN,
    parameter int                PHASE_W      = DEF_PHASE_W,
    parameter int                LUT_AW       = DEF_LUT_AW,
    parameter int                FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter logic [DATA_W-1:0] IDLE_OUT     = DEF_IDLE_OUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PHASE_W-1:0]        fcw,
    input  logic [BITS_PER_SYM-1:0]   din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic signed [DATA_W-1:0]  out,
    output logic                      out_valid,
    output logic                      sym_strobe,
    output logic                      underrun,
    output logic                      busy
);

    localparam int CNT_W  = $clog2(SYM_LEN);
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int PROD_W = DATA_W + BITS_PER_SYM;

    logic [BITS_PER_SYM-1:0] mem_q [FIFO_DEPTH];
    logic [FAW-1:0]          wptr_q, rptr_q;
    logic [FAW:0]            cnt_q;
    logic                    full, empty, push, pop, last;

    state_t                  state_q;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [BITS_PER_SYM-1:0] k_q;
    logic                    sym_strobe_q, underrun_q;

    logic signed [DATA_W-1:0] lut_s, sample_d, out_q;
    logic signed [PROD_W-1:0] prod;
    logic                     out_valid_q;

    assign full      = (cnt_q == (FAW+1)'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign din_ready = !full;
    assign push      = din_valid && !full;
    assign last      = (sym_cnt_q == CNT_W'(SYM_LEN - 1));
    assign sym_cnt_d = sym_cnt_q + CNT_W'(1);
    assign phase_d   = phase_q + fcw;

    // Pop decisions use the registered occupancy only, so a same-cycle push
    // never bypasses into an empty FIFO.
    always_comb begin
        pop = 1'b0;
        if (enable && !empty)
            pop = (state_q == IDLE) || (state_q == RUN && last);
    end

    always_ff @(posedge clk)
        if (push) mem_q[wptr_q] <= din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + FAW'(1);
            if (pop)  rptr_q <= rptr_q + FAW'(1);
            if (push && !pop)      cnt_q <= cnt_q + (FAW+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (FAW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sym_cnt_q    <= '0;
            phase_q      <= '0;
            k_q          <= '0;
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q      <= RUN;
                        sym_cnt_q    <= '0;
                        phase_q      <= '0;
                        k_q          <= mem_q[rptr_q];
                        sym_strobe_q <= 1'b1;
                    end
                end
                RUN: begin
                    phase_q <= phase_d;
                    if (!last) begin
                        sym_cnt_q <= sym_cnt_d;
                        if (!enable) state_q <= STOP;
                    end else if (pop) begin
                        // Phase keeps running across the boundary.
                        sym_cnt_q    <= '0;
                        k_q          <= mem_q[rptr_q];
                        sym_strobe_q <= 1'b1;
                    end else begin
                        sym_cnt_q  <= '0;
                        underrun_q <= enable;
                        state_q    <= IDLE;
                    end
                end
                STOP: begin
                    phase_q <= phase_d;
                    if (last) begin
                        sym_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        sym_cnt_q <= sym_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mask_sine_lut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_lut (
        .addr   (phase_q[PHASE_W-1 -: LUT_AW]),
        .sample (lut_s)
    );

    // k is an unsigned level, so it enters the product with a zero sign bit.
    always_comb begin
        prod     = PROD_W'(lut_s) * PROD_W'($signed({1'b0, k_q}));
        sample_d = DATA_W'(prod >>> BITS_PER_SYM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= IDLE_OUT;
            out_valid_q <= 1'b0;
        end else if (state_q != IDLE) begin
            out_q       <= sample_d;
            out_valid_q <= 1'b1;
        end else begin
            out_q       <= IDLE_OUT;
            out_valid_q <= 1'b0;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign sym_strobe = sym_strobe_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mask_modulator.sv
// Randomized bench for mask_modulator with a sample-index reference model:
// sample n of a stream uses phase n*fcw mod 256 and the level of symbol n/8.
module tb_mask_modulator;

    localparam logic signed [15:0] IDLE = 16'h2710;

    logic        clk = 1'b0;
    logic        reset, enable, din_valid;
    logic [7:0]  fcw;
    logic [1:0]  din;
    logic        din_ready, out_valid, sym_strobe, underrun, busy;
    logic signed [15:0] out_w;

    int n_tests = 0;
    int n_fail  = 0;
    int model_q[$];
    int exp_q[$];
    logic signed [15:0] c_out[$];
    bit c_vld[$], c_stb[$], c_und[$], c_busy[$];

    mask_modulator #(
        .DATA_W(16), .BITS_PER_SYM(2), .SYM_LEN(8), .PHASE_W(8),
        .LUT_AW(4), .FIFO_DEPTH(4), .IDLE_OUT(16'h2710)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fcw(fcw), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .out(out_w),
        .out_valid(out_valid), .sym_strobe(sym_strobe), .underrun(underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_sample(input int k, input int ph);
        real v;
        int  lut;
        v   = $sin(2.0 * 3.14159265358979 * real'(ph / 16) / 16.0) * 32767.0;
        lut = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return (lut * k) >>> 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; enable = 1'b0; din_valid = 1'b0; din = '0; fcw = 8'd64;
        tick(); tick();
        reset = 1'b0;
        model_q.delete();
    endtask

    // Model accepts only while it holds fewer than FIFO_DEPTH symbols.
    task automatic push(input int k);
        din = 2'(k); din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        if (model_q.size() < 4) model_q.push_back(k);
    endtask

    task automatic build_exp(input int nsym, input int f);
        int k;
        exp_q.delete();
        for (int s = 0; s < nsym; s++) begin
            k = model_q.pop_front();
            for (int n = 0; n < 8; n++) exp_q.push_back(ref_sample(k, ((s * 8 + n) * f) % 256));
        end
    endtask

    task automatic capture(input int n);
        c_out.delete(); c_vld.delete(); c_stb.delete(); c_und.delete(); c_busy.delete();
        repeat (n) begin
            tick();
            c_out.push_back(out_w); c_vld.push_back(out_valid); c_stb.push_back(sym_strobe);
            c_und.push_back(underrun); c_busy.push_back(busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; din_valid = 1'b1; din = 2'd3; fcw = 8'd64;
        tick(); tick();
        n_tests++;
        if ({out_w, out_valid, sym_strobe, underrun, busy, din_ready} !== {IDLE, 5'b00001}) begin
            n_fail++;
            $display("FAIL reset: got out=%h v=%b s=%b u=%b b=%b r=%b expected out=2710 v=0 s=0 u=0 b=0 r=1",
                     out_w, out_valid, sym_strobe, underrun, busy, din_ready);
        end
        reset_dut();
    endtask

    task automatic test_single();
        logic signed [15:0] pat [4];
        reset_dut();
        pat[0] = 16'sd0; pat[1] = 16'sd24575; pat[2] = 16'sd0; pat[3] = -16'sd24576;
        push(3);
        enable = 1'b1;
        capture(12);
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (i >= 1 && i <= 8) begin
                if (c_out[i] !== pat[(i - 1) % 4] || !c_vld[i]) begin
                    n_fail++;
                    $display("FAIL single out[%0d]: got %0d v=%b expected %0d v=1", i, c_out[i], c_vld[i], pat[(i - 1) % 4]);
                end
            end else if (c_out[i] !== IDLE || c_vld[i]) begin
                n_fail++;
                $display("FAIL single idle[%0d]: got %h v=%b expected 2710 v=0", i, c_out[i], c_vld[i]);
            end
            n_tests++;
            if ({c_stb[i], c_und[i], c_busy[i]} !== {i == 0, i == 8, i < 8}) begin
                n_fail++;
                $display("FAIL single ctl[%0d]: got s/u/b=%b%b%b expected %b%b%b", i, c_stb[i], c_und[i], c_busy[i], i == 0, i == 8, i < 8);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_fill();
        logic signed [15:0] eo;
        bit ev;
        reset_dut();
        for (int j = 0; j < 4; j++) push($urandom_range(0, 3));
        n_tests++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill ready: got %b expected 0", din_ready);
        end
        push($urandom_range(0, 3));
        build_exp(4, 64);
        enable = 1'b1;
        capture(36);
        for (int i = 0; i < 36; i++) begin
            ev = (i >= 1 && i <= 32);
            eo = IDLE;
            if (ev) eo = 16'(exp_q[i - 1]);
            n_tests++;
            if (c_out[i] !== eo || c_vld[i] !== ev) begin
                n_fail++;
                $display("FAIL fill out[%0d]: got %0d v=%b expected %0d v=%b", i, c_out[i], c_vld[i], eo, ev);
            end
            n_tests++;
            if ({c_stb[i], c_und[i]} !== {i < 32 && i % 8 == 0, i == 32}) begin
                n_fail++;
                $display("FAIL fill strobe[%0d]: got s/u=%b%b expected %b%b", i, c_stb[i], c_und[i], i < 32 && i % 8 == 0, i == 32);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] eo;
        bit ev;
        reset_dut();
        push(0);
        push(2);
        build_exp(2, 64);
        enable = 1'b1;
        capture(20);
        n_tests++;
        if (c_out[10] !== 16'sd16383 || c_out[12] !== -16'sd16384) begin
            n_fail++;
            $display("FAIL b2b peaks: got %0d %0d expected 16383 -16384", c_out[10], c_out[12]);
        end
        for (int i = 0; i < 20; i++) begin
            ev = (i >= 1 && i <= 16);
            eo = IDLE;
            if (ev) eo = 16'(exp_q[i - 1]);
            n_tests++;
            if (c_out[i] !== eo || c_vld[i] !== ev || c_stb[i] !== (i == 0 || i == 8)) begin
                n_fail++;
                $display("FAIL b2b out[%0d]: got %0d v=%b s=%b expected %0d v=%b", i, c_out[i], c_vld[i], c_stb[i], eo, ev);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_stop();
        int nstb;
        reset_dut();
        for (int j = 0; j < 3; j++) push($urandom_range(1, 3));
        build_exp(1, 64);
        nstb = 0;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            nstb += int'(sym_strobe);
            n_tests++;
            if (i >= 1 && i <= 8) begin
                if (out_w !== 16'(exp_q[i - 1]) || !out_valid) begin
                    n_fail++;
                    $display("FAIL stop out[%0d]: got %0d v=%b expected %0d v=1", i, out_w, out_valid, exp_q[i - 1]);
                end
            end else if (out_w !== IDLE || out_valid || busy !== (i < 8)) begin
                n_fail++;
                $display("FAIL stop idle[%0d]: got %h v=%b b=%b expected 2710 v=0 b=%b", i, out_w, out_valid, busy, i < 8);
            end
            if (i == 3) enable = 1'b0;
            if (i == 5) enable = 1'b1;
            if (i == 6) enable = 1'b0;
        end
        n_tests++;
        if (nstb != 1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL stop strobes: got %0d u=%b expected 1 u=0", nstb, underrun);
        end
        // The two symbols still queued must come out intact.
        build_exp(2, 64);
        enable = 1'b1;
        capture(18);
        for (int i = 1; i <= 16; i++) begin
            n_tests++;
            if (c_out[i] !== 16'(exp_q[i - 1]) || !c_vld[i]) begin
                n_fail++;
                $display("FAIL stop resume[%0d]: got %0d v=%b expected %0d v=1", i, c_out[i], c_vld[i], exp_q[i - 1]);
            end
        end
        n_tests++;
        if (c_und[16] !== 1'b1 || c_vld[17] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop end: got u=%b v=%b expected u=1 v=0", c_und[16], c_vld[17]);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        reset_dut();
        push(3);
        push(2);
        enable = 1'b1;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out_w, out_valid, busy, din_ready} !== {IDLE, 3'b001}) begin
            n_fail++;
            $display("FAIL rstmid async: got out=%h v=%b b=%b r=%b expected 2710 0 0 1", out_w, out_valid, busy, din_ready);
        end
        tick();
        reset = 1'b0;
        model_q.delete();
        capture(10);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (c_out[i] !== IDLE || c_vld[i] || c_stb[i] || c_busy[i]) begin
                n_fail++;
                $display("FAIL rstmid quiet[%0d]: got out=%h v=%b s=%b b=%b expected 2710 0 0 0", i, c_out[i], c_vld[i], c_stb[i], c_busy[i]);
            end
        end
        k = $urandom_range(1, 3);
        push(k);
        build_exp(1, 64);
        capture(10);
        n_tests++;
        if (c_stb[0] !== 1'b1 || c_out[2] !== 16'(exp_q[1])) begin
            n_fail++;
            $display("FAIL rstmid restart: got s=%b out=%0d expected s=1 out=%0d", c_stb[0], c_out[2], exp_q[1]);
        end
        enable = 1'b0;
    endtask

    task automatic test_push_at_boundary();
        int k1, k2;
        reset_dut();
        k1 = $urandom_range(1, 3);
        k2 = $urandom_range(1, 3);
        push(k1);
        enable = 1'b1;
        capture(8);
        din = 2'(k2); din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        n_tests++;
        if (underrun !== 1'b1 || busy !== 1'b0 || out_w !== 16'(ref_sample(k1, 448 % 256))) begin
            n_fail++;
            $display("FAIL boundary underrun: got u=%b b=%b out=%0d expected u=1 b=0 out=%0d", underrun, busy, out_w, ref_sample(k1, 192));
        end
        tick();
        n_tests++;
        if (sym_strobe !== 1'b1 || out_w !== IDLE || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary restart: got s=%b out=%h v=%b expected s=1 out=2710 v=0", sym_strobe, out_w, out_valid);
        end
        tick(); tick();
        n_tests++;
        if (out_w !== 16'(ref_sample(k2, 64)) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary phase: got %0d v=%b expected %0d v=1", out_w, out_valid, ref_sample(k2, 64));
        end
        enable = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int ns, f;
        logic signed [15:0] eo;
        bit ev;
        for (int it = 0; it < 6; it++) begin
            reset_dut();
            ns = $urandom_range(1, 4);
            f  = $urandom_range(1, 255);
            fcw = 8'(f);
            for (int j = 0; j < ns; j++) push($urandom_range(0, 3));
            build_exp(ns, f);
            enable = 1'b1;
            capture(8 * ns + 3);
            for (int i = 0; i < 8 * ns + 3; i++) begin
                ev = (i >= 1 && i <= 8 * ns);
                eo = IDLE;
                if (ev) eo = 16'(exp_q[i - 1]);
                n_tests++;
                if (c_out[i] !== eo || c_vld[i] !== ev || c_und[i] !== (i == 8 * ns)) begin
                    n_fail++;
                    $display("FAIL random it%0d fcw=%0d [%0d]: got %0d v=%b u=%b expected %0d v=%b u=%b",
                             it, f, i, c_out[i], c_vld[i], c_und[i], eo, ev, i == 8 * ns);
                end
            end
            enable = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_stop();
        test_reset_mid();
        test_push_at_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
